// File: rtl/sd_spi_pkg.sv
`timescale 1ns/1ps
// sd_spi_pkg: shared types, SD command indices and helper functions for the
// SPI-mode SD command engine.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        RESP_R1   = 2'd0,
        RESP_R1B  = 2'd1,
        RESP_R3R7 = 2'd2,
        RESP_RSVD = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_INIT_CLK,
        ST_IDLE,
        ST_PRE,
        ST_SEND,
        ST_WAIT_R1,
        ST_EXT,
        ST_BUSY,
        ST_POST
    } state_e;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD58  = 6'd58;

    // CRC7 (x^7 + x^3 + 1) over the 40 leading command bits, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb   = d[39-i] ^ c[6];
            c    = {c[5:0], 1'b0};
            c[0] = fb;
            c[3] = c[3] ^ fb;
        end
        return c;
    endfunction

    // SCLK half-period in system clock cycles.
    function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned f_hz);
        return clk_hz / (2 * f_hz);
    endfunction

endpackage

// File: rtl/sd_spi_byte_xfer.sv
`timescale 1ns/1ps
// sd_spi_byte_xfer: full-duplex 8-bit SPI mode-0 shifter with its own SCLK
// divider. A start pulse while idle loads the tx byte; done pulses one cycle
// after the eighth falling edge, with the received byte on rx_o.
module sd_spi_byte_xfer #(
    parameter int unsigned HALF_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        tx_i,
    input  logic [HALF_W-1:0] half_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              done_o,
    output logic [7:0]        rx_o
);

    logic              active_q;
    logic              sclk_q;
    logic              done_q;
    logic [7:0]        tx_q;
    logic [7:0]        rx_q;
    logic [2:0]        bit_q;
    logic [HALF_W-1:0] div_q;

    // Divider and shifter: sample MISO on the rising edge, advance MOSI on the falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= '1;
            rx_q     <= '1;
            bit_q    <= '0;
            div_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (start_i) begin
                    active_q <= 1'b1;
                    tx_q     <= tx_i;
                    bit_q    <= '0;
                    div_q    <= half_i - HALF_W'(1);
                end
            end else if (div_q != '0) begin
                div_q <= div_q - HALF_W'(1);
            end else begin
                div_q <= half_i - HALF_W'(1);
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[6:0], miso_i};
                end else begin
                    sclk_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= {tx_q[6:0], 1'b1};
                    end
                end
            end
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = tx_q[7];
    assign done_o = done_q;
    assign rx_o   = rx_q;

endmodule

// File: rtl/sd_spi_cmd_engine.sv
`timescale 1ns/1ps
// sd_spi_cmd_engine: SPI-mode SD command/response engine. Runs the power-up
// clocks, sends a 48-bit command frame and collects R1, R1b or R3/R7.
// Optional macro SD_CRC7_GEN_EN: generate CRC7 internally instead of using cmd_crc.
module sd_spi_cmd_engine
    import sd_spi_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned SLOW_HZ     = 400000,
    parameter int unsigned FAST_HZ     = 25000000,
    parameter int unsigned INIT_CLOCKS = 80,
    parameter int unsigned NCR_MAX     = 8,
    parameter int unsigned BUSY_MAX    = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic [1:0]  resp_type,
    input  logic        fast_mode,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic        sd_sclk,
    output logic        sd_cs,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    localparam int unsigned SLOW_HALF  = half_div(CLK_HZ, SLOW_HZ);
    localparam int unsigned FAST_HALF  = half_div(CLK_HZ, FAST_HZ);
    localparam int unsigned HALF_W     = $clog2(SLOW_HALF + 1);
    localparam int unsigned INIT_BYTES = (INIT_CLOCKS + 7) / 8;
    localparam int unsigned CNT_MAX    = (BUSY_MAX > INIT_BYTES) ?
                                         ((BUSY_MAX > NCR_MAX) ? BUSY_MAX : NCR_MAX) :
                                         ((INIT_BYTES > NCR_MAX) ? INIT_BYTES : NCR_MAX);
    localparam int unsigned BYTE_W     = $clog2(CNT_MAX + 1);

    localparam logic [HALF_W-1:0] SLOW_H    = HALF_W'(SLOW_HALF);
    localparam logic [HALF_W-1:0] FAST_H    = HALF_W'(FAST_HALF);
    localparam logic [BYTE_W-1:0] INIT_LAST = BYTE_W'(INIT_BYTES - 1);
    localparam logic [BYTE_W-1:0] SEND_LAST = BYTE_W'(5);
    localparam logic [BYTE_W-1:0] NCR_LAST  = BYTE_W'(NCR_MAX - 1);
    localparam logic [BYTE_W-1:0] EXT_LAST  = BYTE_W'(3);
    localparam logic [BYTE_W-1:0] BUSY_LAST = BYTE_W'(BUSY_MAX - 1);

    state_e            state_q;
    resp_type_e        rtype_q;
    logic              go_q;
    logic [7:0]        tx_q;
    logic              cs_q;
    logic [BYTE_W-1:0] cnt_q;
    logic [47:0]       frame_q;
    logic              fast_q;
    logic              ready_q;
    logic              valid_q;
    logic [7:0]        r1_q;
    logic [31:0]       data_q;
    logic              timeout_q;
    logic              miso_s1_q;
    logic              miso_s2_q;

    logic [6:0]        crc_d;
    logic [47:0]       frame_d;
    logic [HALF_W-1:0] half_d;
    logic              xfer_done;
    logic [7:0]        xfer_rx;

`ifdef SD_CRC7_GEN_EN
    assign crc_d = crc7({2'b01, cmd_index, cmd_arg});
`else
    assign crc_d = cmd_crc;
`endif

    assign frame_d = {2'b01, cmd_index, cmd_arg, crc_d, 1'b1};
    assign half_d  = (state_q == ST_INIT_CLK || !fast_q) ? SLOW_H : FAST_H;

    // Two-flop synchroniser for the card's data line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_s1_q <= 1'b1;
            miso_s2_q <= 1'b1;
        end else begin
            miso_s1_q <= sd_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    sd_spi_byte_xfer #(
        .HALF_W (HALF_W)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start_i (go_q),
        .tx_i    (tx_q),
        .half_i  (half_d),
        .miso_i  (miso_s2_q),
        .sclk_o  (sd_sclk),
        .mosi_o  (sd_mosi),
        .done_o  (xfer_done),
        .rx_o    (xfer_rx)
    );

    // Command sequencer: one byte transfer per go pulse, decisions on each done.
    // go_q resets high so the first power-up byte starts right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT_CLK;
            rtype_q   <= RESP_R1;
            go_q      <= 1'b1;
            tx_q      <= 8'hFF;
            cs_q      <= 1'b1;
            cnt_q     <= '0;
            frame_q   <= '0;
            fast_q    <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            r1_q      <= 8'hFF;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            go_q    <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                ST_INIT_CLK: if (xfer_done) begin
                    if (cnt_q == INIT_LAST) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        go_q  <= 1'b1;
                    end
                end
                ST_IDLE: if (cmd_valid && ready_q) begin
                    ready_q   <= 1'b0;
                    frame_q   <= frame_d;
                    rtype_q   <= resp_type_e'(resp_type);
                    fast_q    <= fast_mode;
                    r1_q      <= 8'hFF;
                    data_q    <= '0;
                    timeout_q <= 1'b0;
                    cs_q      <= 1'b0;
                    tx_q      <= 8'hFF;
                    go_q      <= 1'b1;
                    state_q   <= ST_PRE;
                end
                ST_PRE: if (xfer_done) begin
                    cnt_q   <= '0;
                    tx_q    <= frame_q[47:40];
                    go_q    <= 1'b1;
                    state_q <= ST_SEND;
                end
                ST_SEND: if (xfer_done) begin
                    go_q <= 1'b1;
                    if (cnt_q == SEND_LAST) begin
                        cnt_q   <= '0;
                        tx_q    <= 8'hFF;
                        state_q <= ST_WAIT_R1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        tx_q    <= frame_q[39:32];
                        frame_q <= {frame_q[39:0], 8'h00};
                    end
                end
                ST_WAIT_R1: if (xfer_done) begin
                    go_q <= 1'b1;
                    if (!xfer_rx[7]) begin
                        r1_q  <= xfer_rx;
                        cnt_q <= '0;
                        if (rtype_q == RESP_R1B) begin
                            state_q <= ST_BUSY;
                        end else if (rtype_q == RESP_R3R7 && !xfer_rx[2]) begin
                            state_q <= ST_EXT;
                        end else begin
                            cs_q    <= 1'b1;
                            state_q <= ST_POST;
                        end
                    end else if (cnt_q == NCR_LAST) begin
                        timeout_q <= 1'b1;
                        cs_q      <= 1'b1;
                        state_q   <= ST_POST;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_EXT: if (xfer_done) begin
                    go_q   <= 1'b1;
                    data_q <= {data_q[23:0], xfer_rx};
                    if (cnt_q == EXT_LAST) begin
                        cs_q    <= 1'b1;
                        state_q <= ST_POST;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BUSY: if (xfer_done) begin
                    go_q <= 1'b1;
                    if (xfer_rx != 8'h00) begin
                        cs_q    <= 1'b1;
                        state_q <= ST_POST;
                    end else if (cnt_q == BUSY_LAST) begin
                        timeout_q <= 1'b1;
                        r1_q      <= 8'hFF;
                        cs_q      <= 1'b1;
                        state_q   <= ST_POST;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_POST: if (xfer_done) begin
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT_CLK;
            endcase
        end
    end

    assign cmd_ready    = ready_q;
    assign resp_valid   = valid_q;
    assign resp_r1      = r1_q;
    assign resp_data    = data_q;
    assign resp_timeout = timeout_q;
    assign sd_cs        = cs_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
`timescale 1ns/1ps
// tb_sd_spi_cmd_engine: directed and randomized checks of the SD SPI command
// engine against a byte-level card model and reference response rules.
module tb_sd_spi_cmd_engine;

    localparam int NCR_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  cmd_crc = '0;
    logic [1:0]  resp_type = '0;
    logic        fast_mode = 1'b0;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        sd_sclk;
    logic        sd_cs;
    logic        sd_mosi;
    logic        sd_miso = 1'b1;

    int checks = 0;
    int errors = 0;

    // card model state
    logic [7:0] rsp[$];
    logic [7:0] mosi_log[$];
    logic [7:0] mosi_sh;
    int         bitn, byten;
    int         sclk_rises, hi_cnt, last_high, init_bad;
    bit         mon_init;

    always #5 clk = ~clk;

    sd_spi_cmd_engine #(
        .CLK_HZ      (100000000),
        .SLOW_HZ     (400000),
        .FAST_HZ     (25000000),
        .INIT_CLOCKS (80),
        .NCR_MAX     (NCR_MAX),
        .BUSY_MAX    (65535)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_crc      (cmd_crc),
        .resp_type    (resp_type),
        .fast_mode    (fast_mode),
        .resp_valid   (resp_valid),
        .resp_r1      (resp_r1),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .sd_sclk      (sd_sclk),
        .sd_cs        (sd_cs),
        .sd_mosi      (sd_mosi),
        .sd_miso      (sd_miso)
    );

    // Card response stream as seen after the response window opens.
    function automatic logic [7:0] resp_byte(int k);
        if (k >= 0 && k < rsp.size()) return rsp[k];
        return 8'hFF;
    endfunction

    // Card: 1 filler byte + 6 command bytes, then the scripted response stream.
    function automatic logic [7:0] card_byte(int n);
        if (n < 7) return 8'hFF;
        return resp_byte(n - 7);
    endfunction

    function automatic logic [6:0] ref_crc7(logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    // Card side of the bus: capture MOSI, present the next MISO bit after each rise.
    always @(posedge sd_sclk) begin
        logic [7:0] cb;
        sclk_rises++;
        if (sd_cs === 1'b0) begin
            mosi_sh = {mosi_sh[6:0], sd_mosi};
            bitn++;
            if (bitn == 8) begin
                mosi_log.push_back(mosi_sh);
                bitn = 0;
                byten++;
            end
            #1;
            cb = card_byte(byten);
            sd_miso = cb[7 - bitn];
        end
    end

    // SCLK high-time measurement and power-up pin monitor.
    always @(posedge clk) begin
        if (sd_sclk === 1'b1) hi_cnt++;
        else if (hi_cnt != 0) begin
            last_high = hi_cnt;
            hi_cnt = 0;
        end
        if (mon_init && (sd_cs !== 1'b1 || sd_mosi !== 1'b1)) init_bad++;
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        rsp.delete();
        mosi_log.delete();
        bitn = 0;
        byten = 0;
        mosi_sh = '0;
        sd_miso = 1'b1;
    endtask

    task automatic do_reset_and_init(string tag);
        bit ok;
        @(negedge clk);
        sclk_rises = 0; hi_cnt = 0; last_high = 0; init_bad = 0; mon_init = 1;
        rst = 1'b1;
        #1;
        check({tag, " rst sclk"}, sd_sclk, 1'b0);
        check({tag, " rst cs"}, sd_cs, 1'b1);
        check({tag, " rst mosi"}, sd_mosi, 1'b1);
        check({tag, " rst ready"}, cmd_ready, 1'b0);
        check({tag, " rst valid"}, resp_valid, 1'b0);
        check({tag, " rst r1"}, resp_r1, 8'hFF);
        check({tag, " rst data"}, resp_data, 32'h0);
        check({tag, " rst timeout"}, resp_timeout, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ok = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin ok = 1; break; end
        end
        mon_init = 0;
        check({tag, " init ready"}, ok, 1'b1);
        check({tag, " init sclk count"}, sclk_rises, 80);
        check({tag, " init cs/mosi high"}, init_bad, 0);
        check({tag, " init sclk high time"}, last_high, 125);
    endtask

    // Issue one command (fast mode) against the already-scripted card stream.
    task automatic do_cmd(string tag, logic [5:0] idx, logic [31:0] arg, logic [6:0] crc,
                          logic [1:0] typ);
        int          j, nbytes, m, nonff;
        logic [7:0]  r1e;
        logic [31:0] de;
        logic        te;
        logic [47:0] fe, fg;
        logic [6:0]  crcv;
        bit          ok;

        // reference response rules
        j = -1;
        for (int k = 0; k < NCR_MAX; k++) begin
            r1e = resp_byte(k);
            if (!r1e[7]) begin j = k; break; end
        end
        de = 32'h0;
        if (j < 0) begin
            te = 1'b1; r1e = 8'hFF; nbytes = 7 + NCR_MAX;
        end else begin
            te = 1'b0; r1e = resp_byte(j); nbytes = 7 + j + 1;
            if (typ == 2'd2 && !r1e[2]) begin
                de = {resp_byte(j+1), resp_byte(j+2), resp_byte(j+3), resp_byte(j+4)};
                nbytes += 4;
            end else if (typ == 2'd1) begin
                m = j + 1;
                while (resp_byte(m) == 8'h00 && m < j + 1000) m++;
                nbytes += m - j;
            end
        end
`ifdef SD_CRC7_GEN_EN
        crcv = ref_crc7({2'b01, idx, arg});
`else
        crcv = crc;
`endif
        fe = {8'h40 | {2'b00, idx}, arg, crcv, 1'b1};

        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        check({tag, " ready before"}, ok, 1'b1);
        cmd_index = idx; cmd_arg = arg; cmd_crc = crc; resp_type = typ;
        fast_mode = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        check({tag, " ready drop"}, cmd_ready, 1'b0);
        // requests while busy must be ignored, and fast_mode must stay latched
        cmd_index = ~idx; cmd_arg = ~arg; cmd_crc = ~crc; resp_type = ~typ; fast_mode = 1'b0;
        repeat (16) @(negedge clk);
        cmd_valid = 1'b0;

        ok = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin ok = 1; break; end
        end
        check({tag, " resp_valid"}, ok, 1'b1);
        check({tag, " r1"}, resp_r1, r1e);
        check({tag, " data"}, resp_data, de);
        check({tag, " timeout"}, resp_timeout, te);
        check({tag, " bytes with cs low"}, byten, nbytes);
        fg = '0;
        for (int i = 1; i <= 6; i++) fg = {fg[39:0], (i < mosi_log.size()) ? mosi_log[i] : 8'h00};
        check({tag, " mosi frame"}, fg, fe);
        nonff = 0;
        foreach (mosi_log[i]) if ((i < 1 || i > 6) && mosi_log[i] != 8'hFF) nonff++;
        check({tag, " mosi filler bytes"}, nonff, 0);
        check({tag, " sclk fast high time"}, last_high, 2);
        @(negedge clk);
        check({tag, " valid one cycle"}, resp_valid, 1'b0);
        check({tag, " ready after"}, cmd_ready, 1'b1);
        check({tag, " r1 stable"}, resp_r1, r1e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          nf, nb;
        logic [1:0]  typ;
        logic [7:0]  r1v;

        reset_model();
        do_reset_and_init("por");

        // CMD0, card answers 01 after two filler bytes
        reset_model();
        rsp.push_back(8'hFF); rsp.push_back(8'hFF); rsp.push_back(8'h01);
        do_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 2'd0);

        // CMD8 R7 in fast mode
        reset_model();
        rsp.push_back(8'hFF); rsp.push_back(8'h01);
        rsp.push_back(8'h00); rsp.push_back(8'h00); rsp.push_back(8'h01); rsp.push_back(8'hAA);
        do_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h43, 2'd2);

        // no card: MISO stays high
        reset_model();
        do_cmd("nocard", 6'd58, 32'h0, 7'h7E, 2'd0);

        // R1b: R1=00 then busy zeros, FF ends busy
        reset_model();
        rsp.push_back(8'h00);
        repeat (4) rsp.push_back(8'h00);
        rsp.push_back(8'hFF);
        do_cmd("r1b", 6'd12, 32'h0, 7'h30, 2'd1);

        // randomized commands
        for (int n = 0; n < 10; n++) begin
            reset_model();
            nf  = $urandom_range(0, 9);
            typ = 2'($urandom_range(0, 3));
            r1v = 8'($urandom) & 8'h7F;
            for (int k = 0; k < nf; k++) rsp.push_back(8'($urandom) | 8'h80);
            rsp.push_back(r1v);
            if (typ == 2'd2) repeat (4) rsp.push_back(8'($urandom));
            if (typ == 2'd1) begin
                nb = $urandom_range(0, 5);
                repeat (nb) rsp.push_back(8'h00);
                rsp.push_back(8'($urandom_range(1, 255)));
            end
            rsp.push_back(8'($urandom)); rsp.push_back(8'($urandom));
            do_cmd($sformatf("rand%0d", n), 6'($urandom), $urandom, 7'($urandom), typ);
        end

        // reset in the middle of the command frame
        reset_model();
        rsp.push_back(8'hFF); rsp.push_back(8'h01);
        cmd_index = 6'd0; cmd_arg = 32'h0; cmd_crc = 7'h4A; resp_type = 2'd0; fast_mode = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (mosi_log.size() >= 3) begin ok = 1; break; end
        end
        check("midsend reached", ok, 1'b1);
        check("midsend cs low", sd_cs, 1'b0);
        do_reset_and_init("midsend");

        reset_model();
        rsp.push_back(8'hFF); rsp.push_back(8'hFF); rsp.push_back(8'h01);
        do_cmd("cmd0 after reset", 6'd0, 32'h0, 7'h4A, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
